// File: rtl/trigger_event_logger.sv
// Rising-edge event logger: timestamps masked edges into a first-word-fall-through FIFO.
// Macro TRIGGER_EVENT_LOGGER_TIMESTAMP_EN selects a free-running timestamp; otherwise a record sequence number.
module trigger_event_logger #(
  parameter int unsigned N_EVT = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 24
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [N_EVT-1:0]       evt_in,
  input  logic [N_EVT-1:0]       evt_mask,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [N_EVT-1:0] evt_q;
  logic [N_EVT-1:0] rise;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_n;
  logic [AW:0]      rd_ptr_n;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rec;
  logic [31:0]      head_n;
  logic [TS_W-1:0]  stamp;
  logic [15:0]      drop_base;
  logic             wr_req;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;

`ifdef TRIGGER_EVENT_LOGGER_TIMESTAMP_EN
  always_ff @(posedge sys_clk) begin
    if (reset) stamp <= '0;
    else       stamp <= stamp + TS_W'(1);
  end
`else
  always_ff @(posedge sys_clk) begin
    if (reset)       stamp <= '0;
    else if (accept) stamp <= stamp + TS_W'(1);
  end
`endif

  always_comb begin
    rise      = evt_in & ~evt_q & evt_mask;
    wr_req    = |rise;
    fifo_count = wr_ptr - rd_ptr;
    rd_valid  = (wr_ptr != rd_ptr);
    full      = (fifo_count == (AW+1)'(DEPTH));
    pop       = rd_en & rd_valid;
    accept    = wr_req & (~full | pop);
    drop      = wr_req & full & ~pop;
    rec       = {8'(rise), 24'(stamp)};
    wr_ptr_n  = wr_ptr + (AW+1)'(accept);
    rd_ptr_n  = rd_ptr + (AW+1)'(pop);
    drop_base = clr_ovf ? '0 : drop_cnt;
    // Registered head: bypass the incoming record when it becomes the head this cycle.
    if (wr_ptr_n == rd_ptr_n)
      head_n = '0;
    else if (accept && (wr_ptr == rd_ptr_n))
      head_n = rec;
    else
      head_n = mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge sys_clk) begin
    if (!reset && accept) mem[wr_ptr[AW-1:0]] <= rec;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      evt_q    <= '1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      evt_q   <= evt_in;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      rd_data <= head_n;
      // A drop coinciding with clr_ovf counts from a cleared base.
      if (drop) begin
        overflow <= 1'b1;
        if (drop_base != '1) drop_cnt <= drop_base + 16'd1;
        else                 drop_cnt <= drop_base;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end
endmodule
